// File: rtl/layerio_fifo_if.sv
// Handshake and status bundle for layerio_fifo.
// The master side drives writes and reads. The slave side is the FIFO.
interface layerio_fifo_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wrreq;
    logic [WIDTH-1:0] d;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             almost_empty;
    logic             half_full;
    logic             full;
    logic [AW-1:0]    rdusedw;
    logic             rdready;
    logic             rdready2;
    logic             wrready;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output wrreq, d, rdreq,
        input  q, empty, almost_empty, half_full, full, rdusedw,
        input  rdready, rdready2, wrready, err_overflow, err_underflow
    );

    modport slave (
        input  wrreq, d, rdreq,
        output q, empty, almost_empty, half_full, full, rdusedw,
        output rdready, rdready2, wrready, err_overflow, err_underflow
    );
endinterface

// File: rtl/layerio_fifo.sv
// Single-clock FIFO built from a simple dual-port RAM and a registered output word.
// It has a normal-read mode (RDLATENCY=1) and a show-ahead mode where rdreq acknowledges q.
module layerio_fifo #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned DEPTH        = 512,
    parameter bit          RDREQ_AS_ACK = 1'b0
) (
    input logic           clk,
    input logic           resetn,
    layerio_fifo_if.slave io_bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StPrefetch, StValid} state_e;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_rdready;
    logic             r_err_overflow;
    logic             r_err_underflow;
    state_e           r_state;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [AW:0]      w_count_next;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_wr_acc = io_bus.wrreq && !w_full;
    assign w_rd_acc = io_bus.rdreq && !w_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    // Storage is not reset. Its contents are don't-care until they are rewritten.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= io_bus.d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_q             <= '0;
            r_rdready       <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_state         <= StIdle;
        end else begin
            r_count <= w_count_next;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (io_bus.wrreq && w_full) begin
                r_err_overflow <= 1'b1;
            end
            if (io_bus.rdreq && w_empty) begin
                r_err_underflow <= 1'b1;
            end

            if (!RDREQ_AS_ACK) begin
                r_rdready <= w_rd_acc;
                if (w_rd_acc) begin
                    r_q      <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end else begin
                // In show-ahead mode, r_rd_ptr points past the word held in q.
                // Writes that land while the RAM is empty are forwarded from d into q.
                unique case (r_state)
                    StIdle: begin
                        if (w_wr_acc) begin
                            r_q       <= io_bus.d;
                            r_rd_ptr  <= r_rd_ptr + AW'(1);
                            r_rdready <= 1'b1;
                            r_state   <= StValid;
                        end
                    end
                    StPrefetch: begin
                        if (!w_empty) begin
                            r_q       <= r_mem[r_rd_ptr];
                            r_rd_ptr  <= r_rd_ptr + AW'(1);
                            r_rdready <= 1'b1;
                            r_state   <= StValid;
                        end else begin
                            r_rdready <= 1'b0;
                            r_state   <= StIdle;
                        end
                    end
                    StValid: begin
                        if (w_rd_acc) begin
                            if (r_count >= (AW+1)'(2)) begin
                                r_q      <= r_mem[r_rd_ptr];
                                r_rd_ptr <= r_rd_ptr + AW'(1);
                            end else if (w_wr_acc) begin
                                r_q      <= io_bus.d;
                                r_rd_ptr <= r_rd_ptr + AW'(1);
                            end else begin
                                r_rdready <= 1'b0;
                                r_state   <= StIdle;
                            end
                        end
                    end
                    default: begin
                        r_rdready <= 1'b0;
                        r_state   <= StIdle;
                    end
                endcase
            end
        end
    end

    assign io_bus.q             = r_q;
    assign io_bus.rdready       = r_rdready;
    assign io_bus.err_overflow  = r_err_overflow;
    assign io_bus.err_underflow = r_err_underflow;
    assign io_bus.empty         = w_empty;
    assign io_bus.almost_empty  = (r_count <= (AW+1)'(1));
    assign io_bus.half_full     = (r_count >= (AW+1)'(DEPTH / 2));
    assign io_bus.full          = w_full;
    assign io_bus.wrready       = !w_full;
    assign io_bus.rdready2      = (r_count >= (AW+1)'(2));
    assign io_bus.rdusedw       = r_count[AW-1:0];
endmodule

// File: tb/tb_layerio_fifo.sv
// Bench for layerio_fifo. It runs a normal-mode and a show-ahead instance at DEPTH=4.
// Queue models are checked every cycle, and hand-computed literals pin the expected values.
module tb_layerio_fifo;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    layerio_fifo_if #(.WIDTH(W), .DEPTH(D)) bn ();
    layerio_fifo_if #(.WIDTH(W), .DEPTH(D)) bs ();

    layerio_fifo #(.WIDTH(W), .DEPTH(D), .RDREQ_AS_ACK(1'b0)) u_norm (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bn)
    );

    layerio_fifo #(.WIDTH(W), .DEPTH(D), .RDREQ_AS_ACK(1'b1)) u_sa (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bs)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: word lists in arrival order, plus the normal-mode output register.
    logic [W-1:0] qn[$];
    logic [W-1:0] qs[$];
    logic [W-1:0] n_q   = '0;
    logic         n_rdy = 1'b0;
    logic         n_ovf = 1'b0;
    logic         n_unf = 1'b0;
    logic         s_ovf = 1'b0;
    logic         s_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input string p, input int n, input logic e, ae, hf, f, wr, r2,
                             input logic [1:0] used);
        chk({p, ".empty"}, 32'(e), 32'(n == 0));
        chk({p, ".almost_empty"}, 32'(ae), 32'(n <= 1));
        chk({p, ".half_full"}, 32'(hf), 32'(n >= int'(D / 2)));
        chk({p, ".full"}, 32'(f), 32'(n == int'(D)));
        chk({p, ".wrready"}, 32'(wr), 32'(n != int'(D)));
        chk({p, ".rdready2"}, 32'(r2), 32'(n >= 2));
        chk({p, ".rdusedw"}, 32'(used), 32'(n % int'(D)));
    endtask

    task automatic lit_reset(input string p, input logic e, ae, hf, f, wr, r2,
                             input logic [1:0] used, input logic [W-1:0] q,
                             input logic rdy, ovf, unf);
        chk({p, ".rst_empty"}, 32'(e), 32'd1);
        chk({p, ".rst_almost_empty"}, 32'(ae), 32'd1);
        chk({p, ".rst_half_full"}, 32'(hf), 32'd0);
        chk({p, ".rst_full"}, 32'(f), 32'd0);
        chk({p, ".rst_wrready"}, 32'(wr), 32'd1);
        chk({p, ".rst_rdready2"}, 32'(r2), 32'd0);
        chk({p, ".rst_rdusedw"}, 32'(used), 32'd0);
        chk({p, ".rst_q"}, 32'(q), 32'd0);
        chk({p, ".rst_rdready"}, 32'(rdy), 32'd0);
        chk({p, ".rst_err_overflow"}, 32'(ovf), 32'd0);
        chk({p, ".rst_err_underflow"}, 32'(unf), 32'd0);
    endtask

    // Model update on the DUT's edges. Inputs change 1 time unit after posedge.
    initial begin
        logic wa;
        logic ra;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                qn.delete();
                qs.delete();
                n_q   = '0;
                n_rdy = 1'b0;
                n_ovf = 1'b0;
                n_unf = 1'b0;
                s_ovf = 1'b0;
                s_unf = 1'b0;
            end else begin
                wa = bn.wrreq && (qn.size() != int'(D));
                ra = bn.rdreq && (qn.size() != 0);
                if (bn.wrreq && qn.size() == int'(D)) n_ovf = 1'b1;
                if (bn.rdreq && qn.size() == 0) n_unf = 1'b1;
                n_rdy = ra;
                if (ra) n_q = qn.pop_front();
                if (wa) qn.push_back(bn.d);

                wa = bs.wrreq && (qs.size() != int'(D));
                ra = bs.rdreq && (qs.size() != 0);
                if (bs.wrreq && qs.size() == int'(D)) s_ovf = 1'b1;
                if (bs.rdreq && qs.size() == 0) s_unf = 1'b1;
                if (ra) void'(qs.pop_front());
                if (wa) qs.push_back(bs.d);
            end
        end
    end

    always @(negedge clk) begin
        chk_flags("norm", qn.size(), bn.empty, bn.almost_empty, bn.half_full, bn.full,
                  bn.wrready, bn.rdready2, bn.rdusedw);
        chk("norm.q", 32'(bn.q), 32'(n_q));
        chk("norm.rdready", 32'(bn.rdready), 32'(n_rdy));
        chk("norm.err_overflow", 32'(bn.err_overflow), 32'(n_ovf));
        chk("norm.err_underflow", 32'(bn.err_underflow), 32'(n_unf));
        chk_flags("sa", qs.size(), bs.empty, bs.almost_empty, bs.half_full, bs.full,
                  bs.wrready, bs.rdready2, bs.rdusedw);
        chk("sa.rdready", 32'(bs.rdready), 32'(qs.size() != 0));
        if (qs.size() != 0) chk("sa.q", 32'(bs.q), 32'(qs[0]));
        chk("sa.err_overflow", 32'(bs.err_overflow), 32'(s_ovf));
        chk("sa.err_underflow", 32'(bs.err_underflow), 32'(s_unf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bn.wrreq = 1'b0;
        bn.rdreq = 1'b0;
        bs.wrreq = 1'b0;
        bs.rdreq = 1'b0;
    endtask

    task automatic wr_n(input logic [W-1:0] v);
        bn.wrreq = 1'b1;
        bn.d     = v;
        step();
        bn.wrreq = 1'b0;
    endtask

    task automatic wr_s(input logic [W-1:0] v);
        bs.wrreq = 1'b1;
        bs.d     = v;
        step();
        bs.wrreq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        bn.d = '0;
        bs.d = '0;
        repeat (3) step();
        lit_reset("norm", bn.empty, bn.almost_empty, bn.half_full, bn.full, bn.wrready,
                  bn.rdready2, bn.rdusedw, bn.q, bn.rdready, bn.err_overflow, bn.err_underflow);
        resetn = 1'b1;

        // Normal mode. The first write lands on the first edge after reset is released.
        wr_n(8'h0A);
        wr_n(8'h0B);
        wr_n(8'h0C);
        chk("lit033.rdusedw", 32'(bn.rdusedw), 32'd3);
        chk("lit033.half_full", 32'(bn.half_full), 32'd1);
        bn.rdreq = 1'b1;
        step();
        bn.rdreq = 1'b0;
        chk("lit033.q", 32'(bn.q), 32'h0A);
        chk("lit033.rdready", 32'(bn.rdready), 32'd1);
        chk("lit033.rdusedw2", 32'(bn.rdusedw), 32'd2);
        step();
        chk("lit033.pulse_end", 32'(bn.rdready), 32'd0);
        chk("lit033.q_hold", 32'(bn.q), 32'h0A);

        wr_n(8'h0D);
        wr_n(8'h0E);
        chk("lit034.full", 32'(bn.full), 32'd1);
        chk("lit034.rdusedw", 32'(bn.rdusedw), 32'd0);
        chk("lit034.wrready", 32'(bn.wrready), 32'd0);
        wr_n(8'hEE);
        chk("lit034.err_overflow", 32'(bn.err_overflow), 32'd1);
        bn.rdreq = 1'b1;
        repeat (4) step();
        bn.rdreq = 1'b0;
        chk("lit034.last_q", 32'(bn.q), 32'h0E);
        chk("lit034.drained", 32'(bn.empty), 32'd1);
        chk("lit034.sticky", 32'(bn.err_overflow), 32'd1);

        bn.rdreq = 1'b1;
        bn.wrreq = 1'b1;
        bn.d     = 8'h05;
        step();
        idle_all();
        chk("lit035.rdusedw", 32'(bn.rdusedw), 32'd1);
        chk("lit035.rdready", 32'(bn.rdready), 32'd0);
        chk("lit035.err_underflow", 32'(bn.err_underflow), 32'd1);
        bn.rdreq = 1'b1;
        step();
        bn.rdreq = 1'b0;
        chk("lit035.q", 32'(bn.q), 32'h05);
        chk("lit035.rdready2", 32'(bn.rdready), 32'd1);

        // Show-ahead mode.
        wr_s(8'h11);
        chk("lit036.q11", 32'(bs.q), 32'h11);
        chk("lit036.rdready11", 32'(bs.rdready), 32'd1);
        wr_s(8'h22);
        bs.rdreq = 1'b1;
        step();
        bs.rdreq = 1'b0;
        chk("lit036.q22", 32'(bs.q), 32'h22);
        bs.rdreq = 1'b1;
        step();
        bs.rdreq = 1'b0;
        chk("lit036.rdready_drop", 32'(bs.rdready), 32'd0);
        chk("lit036.empty", 32'(bs.empty), 32'd1);

        // An empty show-ahead FIFO gets a read and a write together, then a same-slot bypass at N=1.
        bs.rdreq = 1'b1;
        bs.wrreq = 1'b1;
        bs.d     = 8'h33;
        step();
        chk("sa_rw_empty.q", 32'(bs.q), 32'h33);
        chk("sa_rw_empty.err_underflow", 32'(bs.err_underflow), 32'd1);
        bs.d = 8'h44;
        step();
        idle_all();
        chk("sa_bypass.q", 32'(bs.q), 32'h44);
        chk("sa_bypass.rdusedw", 32'(bs.rdusedw), 32'd1);
        wr_s(8'h55);
        wr_s(8'h66);
        wr_s(8'h77);
        chk("sa_fill.full", 32'(bs.full), 32'd1);
        bs.rdreq = 1'b1;
        bs.wrreq = 1'b1;
        bs.d     = 8'h88;
        step();
        idle_all();
        chk("sa_full_rw.rdusedw", 32'(bs.rdusedw), 32'd3);
        chk("sa_full_rw.q", 32'(bs.q), 32'h55);
        chk("sa_full_rw.err_overflow", 32'(bs.err_overflow), 32'd1);

        // Pointer wrap: both FIFOs sit at N=DEPTH-1 with simultaneous read and write.
        wr_n(8'h61);
        wr_n(8'h62);
        wr_n(8'h63);
        for (int i = 0; i < 3 * int'(D); i++) begin
            bn.rdreq = 1'b1;
            bn.wrreq = 1'b1;
            bn.d     = 8'h70 + W'(i);
            bs.rdreq = 1'b1;
            bs.wrreq = 1'b1;
            bs.d     = 8'h90 + W'(i);
            step();
        end
        idle_all();
        chk("lit037.norm_rdusedw", 32'(bn.rdusedw), 32'd3);
        chk("lit037.norm_q", 32'(bn.q), 32'h78);
        chk("lit037.sa_rdusedw", 32'(bs.rdusedw), 32'd3);
        chk("lit037.sa_q", 32'(bs.q), 32'h99);

        // Reset asserted mid-burst with N=3 in both FIFOs.
        bn.wrreq = 1'b1;
        bn.d     = 8'hAA;
        bs.rdreq = 1'b1;
        resetn   = 1'b0;
        #1;
        lit_reset("norm", bn.empty, bn.almost_empty, bn.half_full, bn.full, bn.wrready,
                  bn.rdready2, bn.rdusedw, bn.q, bn.rdready, bn.err_overflow, bn.err_underflow);
        lit_reset("sa", bs.empty, bs.almost_empty, bs.half_full, bs.full, bs.wrready,
                  bs.rdready2, bs.rdusedw, bs.q, bs.rdready, bs.err_overflow, bs.err_underflow);
        idle_all();
        step();
        step();
        resetn   = 1'b1;
        bn.wrreq = 1'b1;
        bn.d     = 8'h07;
        bs.wrreq = 1'b1;
        bs.d     = 8'h07;
        step();
        idle_all();
        chk("lit038.sa_q", 32'(bs.q), 32'h07);
        chk("lit038.sa_rdready", 32'(bs.rdready), 32'd1);
        bn.rdreq = 1'b1;
        step();
        bn.rdreq = 1'b0;
        chk("lit038.norm_q", 32'(bn.q), 32'h07);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layerio_fifo.md
LAYERIO_FIFO -- requirements
Module: layerio_fifo

Parameters
REQ-001 SHALL have parameter WIDTH, default 64, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, meaning word capacity; power of two, minimum 4.
REQ-003 SHALL have parameter RDREQ_AS_ACK, default globals::FALSE: FALSE = normal read (rdreq requests a word); TRUE = show-ahead (rdreq acknowledges the word on q).

Interface
REQ-004 SHALL have clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have wrreq, input, 1, write request.
REQ-007 SHALL have d, input, WIDTH, write data.
REQ-008 SHALL have rdreq, input, 1, read request or acknowledge per RDREQ_AS_ACK.
REQ-009 SHALL have q, output, WIDTH, registered read data.
REQ-010 SHALL have empty / almost_empty / half_full / full, outputs, 1 each, occupancy flags.
REQ-011 SHALL have rdusedw, output, $clog2(DEPTH), occupancy count modulo DEPTH.
REQ-012 SHALL have rdready / rdready2 / wrready, outputs, 1 each, read-valid, two-words-available and write-accept qualifiers.
REQ-013 SHALL have err_overflow / err_underflow, outputs, 1 each, sticky error flags.

Function
REQ-014 SHALL keep an internal count N (0..DEPTH, $clog2(DEPTH)+1 bits); rdusedw = N[$clog2(DEPTH)-1:0], so rdusedw reads 0 when full.
REQ-015 SHALL accept a write iff wrreq && !full, storing d at the write pointer; the write pointer wraps DEPTH-1 -> 0.
REQ-016 SHALL accept a read iff rdreq && !empty; the read pointer wraps DEPTH-1 -> 0.
REQ-017 SHALL update N on each edge by +1 (write only), -1 (read only), or 0 (both accepted, or neither).
REQ-018 SHALL derive all flags combinationally from registered N: empty = (N==0); almost_empty = (N<=1); half_full = (N>=DEPTH/2); full = (N==DEPTH); wrready = !full; rdready2 = (N>=2).
REQ-019 SHALL, when full with wrreq and an accepted rdreq in the same cycle, reject the write; N ends at DEPTH-1.
REQ-020 SHALL, when empty with rdreq and wrreq in the same cycle, accept the write only; N ends at 1.
REQ-021 SHALL set err_overflow on wrreq && full, and err_underflow on rdreq && empty; both hold until reset.
REQ-022 SHALL, in normal mode, load q one cycle after an accepted read (RDLATENCY=1), pulse rdready high for exactly that cycle, and hold q otherwise.
REQ-023 SHALL, in show-ahead mode, present the head word on q with rdready = !empty (level).
REQ-024 SHALL, in show-ahead mode, make a word written into an empty FIFO visible on q with rdready=1 in the cycle after the write (WRLATENCY=1).
REQ-025 SHALL, in show-ahead mode, present the next word on q the cycle after an accepted rdreq, or drop rdready if that read emptied the FIFO.
REQ-026 SHALL count the show-ahead output-register word in N.
REQ-027 SHALL implement storage as a simple dual-port RAM plus an output register, using the prefetch state machine {IDLE, PREFETCH, VALID} for show-ahead mode.
REQ-028 SHALL never present stale or duplicated data on q when a read and a write hit the same address in the same cycle (show-ahead bypass).

Reset
REQ-029 SHALL, while resetn=0 and regardless of clk, force: N=0; both pointers=0; q=0; rdready=0; err_overflow=0; err_underflow=0; prefetch state=IDLE.
REQ-030 SHALL, during reset, drive empty=1, almost_empty=1, full=0, half_full=0, wrready=1, rdready2=0.
REQ-031 SHALL discard all stored contents on reset asserted mid-operation; RAM contents are don't-care after reset.
REQ-032 SHALL accept the first write on the first rising edge after resetn deasserts.

Verification
REQ-033 SHALL cover normal mode, DEPTH=4: write 0xA,0xB,0xC -> N=3, half_full=1; rdreq one cycle -> q=0xA with rdready pulse one cycle later, N=2.
REQ-034 SHALL cover fill to DEPTH=4 -> full=1, rdusedw=0, wrready=0; extra wrreq -> data dropped, err_overflow=1 and sticky.
REQ-035 SHALL cover, when empty, simultaneous rdreq+wrreq(0x5) -> N=1, no rdready, err_underflow=1; next-cycle read -> q=0x5.
REQ-036 SHALL cover show-ahead mode: write 0x11 into empty -> next cycle q=0x11, rdready=1; write 0x22, then rdreq -> q=0x22 next cycle; rdreq -> rdready=0, empty=1.
REQ-037 SHALL cover pointer wrap: 3*DEPTH writes interleaved with reads at N=DEPTH-1 and simultaneous rd/wr -> output sequence matches input order, N constant.
REQ-038 SHALL cover reset asserted mid-burst with N=3 -> flags and outputs immediately match REQ-029/030; a post-reset write of 0x7 -> read returns 0x7.
